// File: rtl/inst_bus_arbiter.sv
// Round-robin arbiter sharing one instruction-memory port between NUM_REQ fetch requesters.
// A small ID FIFO sends in-order read responses back to the requester that issued each read.

package bus_params_pkg;
  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;
endpackage

module inst_bus_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int BUS_AW          = bus_params_pkg::BUS_AW,
  parameter int BUS_DW          = bus_params_pkg::BUS_DW,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*BUS_AW-1:0] addr_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        rvalid_o,
  output logic [BUS_DW-1:0]         rdata_o,
  output logic                      inst_req_o,
  output logic [BUS_AW-1:0]         inst_addr_o,
  input  logic                      inst_gnt_i,
  input  logic                      inst_rvalid_i,
  input  logic [BUS_DW-1:0]         inst_rdata_i,
  output logic                      err_o
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int PW  = $clog2(MAX_OUTSTANDING);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(MAX_OUTSTANDING);

  localparam logic [0:0] ARB  = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  // Returns {found, index} of the first set request at or after ptr, wrapping around.
  function automatic logic [IDW:0] pick_rr(input logic [NUM_REQ-1:0] req,
                                           input logic [IDW-1:0]     ptr);
    logic [IDW:0]   res;
    logic [IDW-1:0] idx;
    res = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = IDW'((int'(ptr) + i) % NUM_REQ);
      if (req[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Expands a requester index into its one-hot lane.
  function automatic logic [NUM_REQ-1:0] to_onehot(input logic [IDW-1:0] id);
    logic [NUM_REQ-1:0] oh;
    for (int k = 0; k < NUM_REQ; k++) begin
      oh[k] = (id == IDW'(k));
    end
    return oh;
  endfunction

  logic [0:0]         state_r;
  logic [IDW-1:0]     sel_r;
  logic [IDW-1:0]     rr_ptr_r;
  logic [IDW-1:0]     id_mem_r [MAX_OUTSTANDING];
  logic [PW-1:0]      wr_ptr_r;
  logic [PW-1:0]      rd_ptr_r;
  logic [PW:0]        count_r;
  logic               err_r;

  logic               full_s;
  logic               empty_s;
  logic [IDW:0]       pick_s;
  logic               req_s;
  logic [IDW-1:0]     cur_sel_s;
  logic [IDW-1:0]     rr_next_s;
  logic [BUS_AW-1:0]  addr_s;
  logic               push_s;
  logic               pop_s;
  logic [IDW-1:0]     head_id_s;

  assign full_s    = (count_r == FULL_CNT);
  assign empty_s   = (count_r == '0);
  assign pick_s    = pick_rr(req_i, rr_ptr_r);
  assign head_id_s = id_mem_r[rd_ptr_r];

  // Request generation: ARB picks a new requester, HOLD keeps the stalled one.
  always_comb begin
    req_s     = 1'b0;
    cur_sel_s = sel_r;
    case (state_r)
      ARB: begin
        if (!full_s && pick_s[IDW]) begin
          req_s     = 1'b1;
          cur_sel_s = pick_s[IDW-1:0];
        end else begin
          req_s     = 1'b0;
          cur_sel_s = sel_r;
        end
      end
      HOLD: begin
        req_s     = 1'b1;
        cur_sel_s = sel_r;
      end
      default: begin
        req_s     = 1'b0;
        cur_sel_s = sel_r;
      end
    endcase
  end

  // Address mux for the selected requester; zero while idle.
  always_comb begin
    addr_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      addr_s = (req_s && (cur_sel_s == IDW'(k))) ? addr_i[k*BUS_AW +: BUS_AW] : addr_s;
    end
  end

  assign rr_next_s = (cur_sel_s == IDW'(NUM_REQ - 1)) ? '0 : cur_sel_s + IDW'(1);
  assign push_s    = req_s & inst_gnt_i;
  assign pop_s     = inst_rvalid_i & ~empty_s;

  assign inst_req_o  = req_s;
  assign inst_addr_o = addr_s;
  assign gnt_o       = push_s ? to_onehot(cur_sel_s) : '0;
  assign rvalid_o    = pop_s ? to_onehot(head_id_s) : '0;
  assign rdata_o     = inst_rdata_i;
  assign err_o       = err_r;

  // Arbitration FSM, held selection and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ARB;
      sel_r    <= '0;
      rr_ptr_r <= '0;
    end else begin
      case (state_r)
        ARB: begin
          if (req_s && !inst_gnt_i) begin
            state_r <= HOLD;
            sel_r   <= cur_sel_s;
          end else begin
            state_r <= ARB;
          end
        end
        HOLD: begin
          if (inst_gnt_i) begin
            state_r <= ARB;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          state_r <= ARB;
        end
      endcase
      if (push_s) begin
        rr_ptr_r <= rr_next_s;
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
    end
  end

  // ID FIFO storage: one requester index per granted, unanswered read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        id_mem_r[i] <= '0;
      end
    end else if (push_s) begin
      id_mem_r[wr_ptr_r] <= cur_sel_s;
    end else begin
      id_mem_r[wr_ptr_r] <= id_mem_r[wr_ptr_r];
    end
  end

  // ID FIFO pointers and occupancy; a same-cycle push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PW+1)'(1);
        2'b01:   count_r <= count_r - (PW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky error: a response arrived with nothing outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (inst_rvalid_i && empty_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

endmodule

// File: tb/tb_inst_bus_arbiter.sv
// Self-checking bench for inst_bus_arbiter: per-scenario tasks, response IDs checked via a queue.

module tb_inst_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_i;
  logic [31:0] a0, a1;
  logic [63:0] addr_i;
  logic [1:0]  gnt_o, rvalid_o;
  logic [31:0] rdata_o;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_gnt_i, inst_rvalid_i;
  logic [31:0] inst_rdata_i;
  logic        err_o;

  int checks = 0;
  int passes = 0;
  logic [1:0] exp_q[$];
  logic [1:0] exp_id;

  assign addr_i = {a1, a0};

  always #5 clk = ~clk;

  inst_bus_arbiter #(.NUM_REQ(2), .BUS_AW(32), .BUS_DW(32), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .addr_i(addr_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .inst_req_o(inst_req_o), .inst_addr_o(inst_addr_o),
    .inst_gnt_i(inst_gnt_i), .inst_rvalid_i(inst_rvalid_i),
    .inst_rdata_i(inst_rdata_i), .err_o(err_o)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    req_i = 2'b00; inst_gnt_i = 1'b0; inst_rvalid_i = 1'b0; inst_rdata_i = 32'h0;
  endtask

  task automatic apply_reset;
    idle_inputs();
    rst_n = 1'b0;
    exp_q.delete();
    tick();
    rst_n = 1'b1;
  endtask

  // Pops the next expected response lane; an empty queue yields 2'b00.
  task automatic pop_expected(output logic [1:0] id);
    if (exp_q.size() == 0) id = 2'b00;
    else id = exp_q.pop_front();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle_inputs();
    a0 = 32'h0000_0100; a1 = 32'h0000_0200;
    @(negedge clk);
    checks++; if (inst_req_o !== 1'b0) $display("FAIL reset_req: got %b exp 0", inst_req_o); else passes++;
    checks++; if (inst_addr_o !== 32'h0) $display("FAIL reset_addr: got %h exp 0", inst_addr_o); else passes++;
    checks++; if (gnt_o !== 2'b00) $display("FAIL reset_gnt: got %b exp 00", gnt_o); else passes++;
    checks++; if (rvalid_o !== 2'b00) $display("FAIL reset_rvalid: got %b exp 00", rvalid_o); else passes++;
    checks++; if (err_o !== 1'b0) $display("FAIL reset_err: got %b exp 0", err_o); else passes++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single;
    req_i = 2'b01; inst_gnt_i = 1'b1;
    @(negedge clk);
    checks++; if (inst_req_o !== 1'b1) $display("FAIL t1_req: got %b exp 1", inst_req_o); else passes++;
    checks++; if (inst_addr_o !== 32'h100) $display("FAIL t1_addr: got %h exp 100", inst_addr_o); else passes++;
    checks++; if (gnt_o !== 2'b01) $display("FAIL t1_gnt: got %b exp 01", gnt_o); else passes++;
    exp_q.push_back(2'b01);
    tick();
    req_i = 2'b00; inst_gnt_i = 1'b0; inst_rvalid_i = 1'b1; inst_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    pop_expected(exp_id);
    checks++; if (rvalid_o !== exp_id) $display("FAIL t1_rvalid: got %b exp %b", rvalid_o, exp_id); else passes++;
    checks++; if (rdata_o !== 32'hDEAD_BEEF) $display("FAIL t1_rdata: got %h exp deadbeef", rdata_o); else passes++;
    checks++; if (gnt_o !== 2'b00) $display("FAIL t1_gnt_idle: got %b exp 00", gnt_o); else passes++;
    tick();
    idle_inputs();
  endtask

  task automatic test_alternate;
    logic [1:0] eg;
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      req_i         = (i < 8) ? 2'b11 : 2'b00;
      inst_gnt_i    = 1'b1;
      inst_rvalid_i = (i > 0);
      inst_rdata_i  = 32'h1000 + 32'(i);
      @(negedge clk);
      eg = (i >= 8) ? 2'b00 : ((i % 2 == 0) ? 2'b01 : 2'b10);
      checks++; if (gnt_o !== eg) $display("FAIL t2_gnt[%0d]: got %b exp %b", i, gnt_o, eg); else passes++;
      if (i > 0) begin
        pop_expected(exp_id);
        checks++; if (rvalid_o !== exp_id) $display("FAIL t2_rvalid[%0d]: got %b exp %b", i, rvalid_o, exp_id); else passes++;
        checks++; if (rdata_o !== 32'h1000 + 32'(i)) $display("FAIL t2_rdata[%0d]: got %h", i, rdata_o); else passes++;
      end
      if (eg != 2'b00) exp_q.push_back(eg);
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_hold;
    apply_reset();
    a0 = 32'h0000_0A00; a1 = 32'h0000_0B10;
    for (int c = 0; c < 4; c++) begin
      req_i      = (c == 0) ? 2'b10 : 2'b11;
      inst_gnt_i = (c == 3);
      @(negedge clk);
      checks++; if (inst_req_o !== 1'b1) $display("FAIL t3_req[%0d]: got %b exp 1", c, inst_req_o); else passes++;
      checks++; if (inst_addr_o !== 32'h0B10) $display("FAIL t3_addr[%0d]: got %h exp 0b10", c, inst_addr_o); else passes++;
      checks++; if (gnt_o !== ((c == 3) ? 2'b10 : 2'b00)) $display("FAIL t3_gnt[%0d]: got %b", c, gnt_o); else passes++;
      if (c == 3) exp_q.push_back(2'b10);
      tick();
    end
    req_i = 2'b01; inst_gnt_i = 1'b1;
    @(negedge clk);
    checks++; if (gnt_o !== 2'b01) $display("FAIL t3_next_gnt: got %b exp 01", gnt_o); else passes++;
    checks++; if (inst_addr_o !== 32'h0A00) $display("FAIL t3_next_addr: got %h exp 0a00", inst_addr_o); else passes++;
    exp_q.push_back(2'b01);
    tick();
    idle_inputs();
    for (int r = 0; r < 2; r++) begin
      inst_rvalid_i = 1'b1; inst_rdata_i = 32'h5000 + 32'(r);
      @(negedge clk);
      pop_expected(exp_id);
      checks++; if (rvalid_o !== exp_id) $display("FAIL t3_rvalid[%0d]: got %b exp %b", r, rvalid_o, exp_id); else passes++;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_full;
    apply_reset();
    req_i = 2'b01; inst_gnt_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (gnt_o !== 2'b01) $display("FAIL t4_gnt[%0d]: got %b exp 01", c, gnt_o); else passes++;
      exp_q.push_back(2'b01);
      tick();
    end
    @(negedge clk);
    checks++; if (inst_req_o !== 1'b0) $display("FAIL t4_full_req: got %b exp 0", inst_req_o); else passes++;
    checks++; if (gnt_o !== 2'b00) $display("FAIL t4_full_gnt: got %b exp 00", gnt_o); else passes++;
    tick();
    inst_rvalid_i = 1'b1; inst_rdata_i = 32'h7777_0000;
    @(negedge clk);
    checks++; if (inst_req_o !== 1'b0) $display("FAIL t4_pop_req: got %b exp 0", inst_req_o); else passes++;
    pop_expected(exp_id);
    checks++; if (rvalid_o !== exp_id) $display("FAIL t4_pop_rvalid: got %b exp %b", rvalid_o, exp_id); else passes++;
    tick();
    inst_rvalid_i = 1'b0;
    @(negedge clk);
    checks++; if (inst_req_o !== 1'b1) $display("FAIL t4_resume_req: got %b exp 1", inst_req_o); else passes++;
    checks++; if (gnt_o !== 2'b01) $display("FAIL t4_resume_gnt: got %b exp 01", gnt_o); else passes++;
    exp_q.push_back(2'b01);
    tick();
    idle_inputs();
    for (int r = 0; r < 4; r++) begin
      inst_rvalid_i = 1'b1;
      @(negedge clk);
      pop_expected(exp_id);
      checks++; if (rvalid_o !== exp_id) $display("FAIL t4_drain[%0d]: got %b exp %b", r, rvalid_o, exp_id); else passes++;
      tick();
    end
    idle_inputs();
    @(negedge clk);
    checks++; if (err_o !== 1'b0) $display("FAIL t4_err: got %b exp 0", err_o); else passes++;
    tick();
  endtask

  task automatic test_spurious;
    inst_rvalid_i = 1'b1; inst_rdata_i = 32'hCAFE_F00D;
    @(negedge clk);
    checks++; if (rvalid_o !== 2'b00) $display("FAIL t5_rvalid: got %b exp 00", rvalid_o); else passes++;
    checks++; if (rdata_o !== 32'hCAFE_F00D) $display("FAIL t5_rdata: got %h exp cafef00d", rdata_o); else passes++;
    tick();
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (err_o !== 1'b1) $display("FAIL t5_err[%0d]: got %b exp 1", c, err_o); else passes++;
      tick();
    end
  endtask

  task automatic test_reset_mid;
    apply_reset();
    @(negedge clk);
    checks++; if (err_o !== 1'b0) $display("FAIL t6_err_clr: got %b exp 0", err_o); else passes++;
    tick();
    req_i = 2'b01; inst_gnt_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (gnt_o !== 2'b01) $display("FAIL t6_gnt[%0d]: got %b exp 01", c, gnt_o); else passes++;
      tick();
    end
    idle_inputs();
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checks++; if ({inst_req_o, gnt_o, rvalid_o, err_o} !== 6'b0) $display("FAIL t6_rst_out: got %b exp 0", {inst_req_o, gnt_o, rvalid_o, err_o}); else passes++;
    checks++; if (inst_addr_o !== 32'h0) $display("FAIL t6_rst_addr: got %h exp 0", inst_addr_o); else passes++;
    tick();
    rst_n = 1'b1;
    inst_rvalid_i = 1'b1;
    @(negedge clk);
    checks++; if (rvalid_o !== 2'b00) $display("FAIL t6_rvalid: got %b exp 00", rvalid_o); else passes++;
    tick();
    idle_inputs();
    @(negedge clk);
    checks++; if (err_o !== 1'b1) $display("FAIL t6_err: got %b exp 1", err_o); else passes++;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_hold();
    test_full();
    test_spurious();
    test_reset_mid();
    checks++; if (exp_q.size() != 0) $display("FAIL sb_leftover: got %0d exp 0", exp_q.size()); else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
